// File: rtl/alu_types.sv
// Shared ALU types: operation encoding, exec-stage entry layout and counter widths.
package alu_types;

  localparam int ALU_W          = 32;
  localparam int ALU_EXEC_OPS_W = 32;
  localparam int ALU_EXEC_OVF_W = 16;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_control_t;

  typedef struct packed {
    logic [ALU_W-1:0] result;
    logic             overflow;
    logic             zero;
    logic             equal;
    alu_control_t     control;
  } alu_exec_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_FULL2 = 2'd2
  } alu_exec_state_t;

  localparam alu_exec_entry_t ALU_EXEC_ENTRY_RST = '{
    result:   {ALU_W{1'b0}},
    overflow: 1'b0,
    zero:     1'b0,
    equal:    1'b0,
    control:  ALU_ADD
  };

endpackage

// File: rtl/alu.sv
// Combinational ALU: arithmetic, logic, compare and shift on two N-bit operands.
module alu
  import alu_types::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  alu_control_t control,
  output logic [N-1:0] result,
  output logic         overflow,
  output logic         zero,
  output logic         equal
);

  localparam int SH_W = $clog2(N);

  // Operation select; overflow is only meaningful for signed add/sub.
  always_comb begin
    result   = {N{1'b0}};
    overflow = 1'b0;
    case (control)
      ALU_ADD: begin
        result   = a + b;
        overflow = (a[N-1] == b[N-1]) && (result[N-1] != a[N-1]);
      end
      ALU_SUB: begin
        result   = a - b;
        overflow = (a[N-1] != b[N-1]) && (result[N-1] != a[N-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL: result = a << b[SH_W-1:0];
      ALU_SRL: result = a >> b[SH_W-1:0];
      default: begin
        result   = {N{1'b0}};
        overflow = 1'b0;
      end
    endcase
  end

  assign zero  = (result == {N{1'b0}});
  assign equal = (a == b);

endmodule

// File: rtl/alu_exec_stage.sv
// Valid/ready execute stage around one alu, with op and overflow counters.
// Define ALU_EXEC_SKID_EN for a second (skid) entry and a registered in_ready.
module alu_exec_stage
  import alu_types::*;
#(
  parameter int N = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N-1:0]              in_a,
  input  logic [N-1:0]              in_b,
  input  alu_control_t              in_control,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N-1:0]              out_result,
  output logic                      out_overflow,
  output logic                      out_zero,
  output logic                      out_equal,
  output alu_control_t              out_control,
  input  logic                      counter_clr,
  output logic [ALU_EXEC_OPS_W-1:0] ops_count,
  output logic [ALU_EXEC_OVF_W-1:0] ovf_count
);

  logic [N-1:0]    alu_result;
  logic            alu_overflow;
  logic            alu_zero;
  logic            alu_equal;
  alu_exec_entry_t alu_entry;
  alu_exec_entry_t head_r;
  alu_exec_entry_t head_next;
  alu_exec_state_t state_r;
  alu_exec_state_t state_next;
  logic            valid_r;
  logic            accept;
  logic            emit;
  logic [ALU_EXEC_OPS_W-1:0] ops_r;
  logic [ALU_EXEC_OVF_W-1:0] ovf_r;

  alu #(.N(N)) u_alu (
    .a        (in_a),
    .b        (in_b),
    .control  (in_control),
    .result   (alu_result),
    .overflow (alu_overflow),
    .zero     (alu_zero),
    .equal    (alu_equal)
  );

  assign alu_entry.result   = alu_result;
  assign alu_entry.overflow = alu_overflow;
  assign alu_entry.zero     = alu_zero;
  assign alu_entry.equal    = alu_equal;
  assign alu_entry.control  = in_control;

`ifdef ALU_EXEC_SKID_EN
  alu_exec_entry_t skid_r;
  alu_exec_entry_t skid_next;
  logic            in_ready_r;

  assign in_ready = in_ready_r;
`else
  assign in_ready = !valid_r || out_ready;
`endif

  assign accept    = in_valid && in_ready;
  assign emit      = valid_r && out_ready;
  assign out_valid = valid_r;

  // Entry FSM: the head register always drives the outputs, skid holds the overflow bundle.
  always_comb begin
    state_next = state_r;
    head_next  = head_r;
`ifdef ALU_EXEC_SKID_EN
    skid_next  = skid_r;
`endif
    case (state_r)
      ST_EMPTY: begin
        if (accept) begin
          head_next  = alu_entry;
          state_next = ST_FULL;
        end else begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (accept && emit) begin
          head_next  = alu_entry;
          state_next = ST_FULL;
        end else if (accept) begin
`ifdef ALU_EXEC_SKID_EN
          skid_next  = alu_entry;
          state_next = ST_FULL2;
`else
          state_next = ST_FULL;
`endif
        end else if (emit) begin
          state_next = ST_EMPTY;
        end else begin
          state_next = ST_FULL;
        end
      end
`ifdef ALU_EXEC_SKID_EN
      ST_FULL2: begin
        if (emit) begin
          head_next  = skid_r;
          state_next = ST_FULL;
        end else begin
          state_next = ST_FULL2;
        end
      end
`endif
      default: begin
        state_next = ST_EMPTY;
        head_next  = ALU_EXEC_ENTRY_RST;
      end
    endcase
  end

  // State, output-valid and entry registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
      valid_r <= 1'b0;
      head_r  <= ALU_EXEC_ENTRY_RST;
    end else begin
      state_r <= state_next;
      valid_r <= (state_next != ST_EMPTY);
      head_r  <= head_next;
    end
  end

`ifdef ALU_EXEC_SKID_EN
  // Skid entry and registered ready, derived only from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_r     <= ALU_EXEC_ENTRY_RST;
      in_ready_r <= 1'b1;
    end else begin
      skid_r     <= skid_next;
      in_ready_r <= (state_next != ST_FULL2);
    end
  end
`endif

  // Accepted-op counter wraps; overflow counter saturates; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_r <= {ALU_EXEC_OPS_W{1'b0}};
      ovf_r <= {ALU_EXEC_OVF_W{1'b0}};
    end else if (counter_clr) begin
      ops_r <= {ALU_EXEC_OPS_W{1'b0}};
      ovf_r <= {ALU_EXEC_OVF_W{1'b0}};
    end else if (accept) begin
      ops_r <= ops_r + ALU_EXEC_OPS_W'(1);
      if (alu_overflow && (ovf_r != {ALU_EXEC_OVF_W{1'b1}})) begin
        ovf_r <= ovf_r + ALU_EXEC_OVF_W'(1);
      end else begin
        ovf_r <= ovf_r;
      end
    end else begin
      ops_r <= ops_r;
      ovf_r <= ovf_r;
    end
  end

  assign out_result   = head_r.result;
  assign out_overflow = head_r.overflow;
  assign out_zero     = head_r.zero;
  assign out_equal    = head_r.equal;
  assign out_control  = head_r.control;
  assign ops_count    = ops_r;
  assign ovf_count    = ovf_r;

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 Parameter: N, default 32, datapath width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  upstream operand bundle valid.
REQ-005 in_ready  output  1  stage can accept a bundle this cycle.
REQ-006 in_a, in_b  input  N each  operands.
REQ-007 in_control  input  alu_control_t  operation select.
REQ-008 out_valid  output  1  result bundle valid.
REQ-009 out_ready  input  1  downstream accepts the bundle.
REQ-010 out_result  output  N  registered ALU result.
REQ-011 out_overflow, out_zero, out_equal  output  1 each  registered ALU flags.
REQ-012 out_control  output  alu_control_t  operation that produced out_result.
REQ-013 counter_clr  input  1  synchronous clear of both counters.
REQ-014 ops_count  output  32  accepted-operation counter.
REQ-015 ovf_count  output  16  overflow-event counter.

Function
REQ-016 Accept on an in_valid && in_ready edge; emit on an out_valid && out_ready edge.
REQ-017 One alu instance computes combinationally on in_a/in_b/in_control; result, flags and control are captured at the accept edge; latency 1 cycle (out_valid high the cycle after accept, if the stage was empty).
REQ-018 Results leave in acceptance order; no bundle is dropped or duplicated.
REQ-019 Output fields are held stable while out_valid && !out_ready.
REQ-020 Entry states: EMPTY, FULL (plus FULL2 with skid, see REQ-028); accept-only: EMPTY->FULL; emit-only: FULL->EMPTY; accept and emit in the same cycle keep the state and replace/advance the data.
REQ-021 ops_count increments by 1 per accept and wraps 0xFFFFFFFF->0.
REQ-022 ovf_count increments per accept whose ALU overflow is 1 and saturates at 0xFFFF.
REQ-023 counter_clr has priority over a same-cycle increment: both counters read 0 the next cycle.
REQ-024 in_a/in_b/in_control are ignored when in_valid is 0.

Reset
REQ-025 rst asserted: out_valid=0, in_ready=1, out_result=0, flags=0, out_control=control.first, ops_count=0, ovf_count=0, state EMPTY.
REQ-026 Reset mid-operation discards every held bundle; no output handshake completes in the reset cycle.
REQ-027 The first accept can occur on the first rising edge after rst deasserts.

Configuration
REQ-028 ALU_EXEC_SKID_EN defined: a second entry (skid) is added; in_ready = !(FULL2), is registered, and has no combinational path from out_ready; a sustained stream with out_ready toggling loses no throughput beyond the two entries.
REQ-029 ALU_EXEC_SKID_EN undefined: single entry; in_ready = !out_valid || out_ready (combinational); full throughput only when out_ready=1.

Structure
REQ-030 alu_control_t stays in the shared types package alu_types.sv; add to it the struct alu_exec_entry_t {result, overflow, zero, equal, control} used for both entry registers.
REQ-031 Exactly one sub-module: the existing alu, instantiated once, unmodified.
REQ-032 Counter widths are named constants in alu_types.sv (ALU_EXEC_OPS_W=32, ALU_EXEC_OVF_W=16).

Verification
REQ-033 ADD 0x7FFFFFFF+0x00000001, out_ready=1 -> next cycle out_result=0x80000000, out_overflow=1, ovf_count=1, ops_count=1.
REQ-034 SUB 0x00000005-0x00000005 -> out_result=0, out_zero=1, out_equal=1, out_overflow=0.
REQ-035 out_ready=0, in_valid=1 for 3 cycles with AND ops 0xF0F0F0F0&0xFF00FF00 -> without skid 1 accepted, with skid 2 accepted, then in_ready=0; out_ready=1 -> 0xF000F000 results emitted in order, fields stable while stalled.
REQ-036 8 back-to-back ADDs (i+i, i=0..7), out_ready=1 -> 8 results on 8 consecutive cycles, ops_count=8.
REQ-037 counter_clr=1 in the same cycle as an overflowing accept -> ops_count=0, ovf_count=0 next cycle; result still emitted.
REQ-038 rst pulsed while out_valid=1 and out_ready=0 -> out_valid=0, in_ready=1, counters 0 immediately (asynchronous), held result never emitted.
